// File: rtl/pc_fetch_ctrl.sv
// Program-counter fetch controller.
// Holds the current fetch address and selects the next one from the
// sequential adder result or a redirect (JumpReg > Jump > BranchTaken).
// A redirect that arrives while fetch is stalled is parked in a pending
// register and applied on the first unstalled edge; the oldest one wins.
// Redirect targets are forced to word alignment, and AddrErr flags any
// redirect that had a misaligned target.
module pc_fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h00000000
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic [31:0] PCAddResult,
   input  logic        BranchTaken,
   input  logic [31:0] BranchTarget,
   input  logic        Jump,
   input  logic [31:0] JumpTarget,
   input  logic        JumpReg,
   input  logic [31:0] JumpRegTarget,
   input  logic        Stall,
   output logic [31:0] PCResult,
   output logic        PCValid,
   output logic        RedirectPending,
   output logic        AddrErr
);

   typedef enum logic [1:0] {
      INIT = 2'b00,
      RUN  = 2'b01,
      HOLD = 2'b10
   } state_t;

   state_t      state_r, state_s;
   logic [31:0] pc_r, pc_s;
   logic [31:0] pend_r, pend_s;
   logic        valid_r, valid_s;
   logic        rdp_r, rdp_s;
   logic        err_r, err_s;

   logic        redir_s;
   logic [31:0] raw_tgt_s;
   logic [31:0] tgt_s;
   logic        misalign_s;

   // Pick the highest-priority redirect request and word-align its target.
   always_comb begin
      redir_s   = 1'b0;
      raw_tgt_s = 32'h00000000;
      if (JumpReg) begin
         redir_s   = 1'b1;
         raw_tgt_s = JumpRegTarget;
      end else if (Jump) begin
         redir_s   = 1'b1;
         raw_tgt_s = JumpTarget;
      end else if (BranchTaken) begin
         redir_s   = 1'b1;
         raw_tgt_s = BranchTarget;
      end else begin
         redir_s   = 1'b0;
         raw_tgt_s = 32'h00000000;
      end
      tgt_s      = {raw_tgt_s[31:2], 2'b00};
      misalign_s = |raw_tgt_s[1:0];
   end

   // Next-state, next-PC, pending capture and registered-output decode.
   always_comb begin
      state_s = state_r;
      pc_s    = pc_r;
      pend_s  = pend_r;
      err_s   = 1'b0;
      case (state_r)
         INIT: begin
            // First edge out of reset only validates the reset PC.
            state_s = RUN;
         end
         RUN: begin
            if (Stall) begin
               if (redir_s) begin
                  pend_s  = tgt_s;
                  err_s   = misalign_s;
                  state_s = HOLD;
               end else begin
                  state_s = RUN;
               end
            end else begin
               if (redir_s) begin
                  pc_s  = tgt_s;
                  err_s = misalign_s;
               end else begin
                  // The adder result is taken verbatim, including wrap to zero.
                  pc_s = PCAddResult;
               end
               state_s = RUN;
            end
         end
         HOLD: begin
            // New redirects are ignored here: the parked one is older.
            if (Stall) begin
               state_s = HOLD;
            end else begin
               pc_s    = pend_r;
               pend_s  = 32'h00000000;
               state_s = RUN;
            end
         end
         default: begin
            state_s = INIT;
            pc_s    = RESET_PC;
            pend_s  = 32'h00000000;
         end
      endcase
      valid_s = (state_s != INIT);
      rdp_s   = (state_s == HOLD);
   end

   // State and output registers; reset forces the INIT picture immediately.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_r <= INIT;
         pc_r    <= RESET_PC;
         pend_r  <= 32'h00000000;
         valid_r <= 1'b0;
         rdp_r   <= 1'b0;
         err_r   <= 1'b0;
      end else begin
         state_r <= state_s;
         pc_r    <= pc_s;
         pend_r  <= pend_s;
         valid_r <= valid_s;
         rdp_r   <= rdp_s;
         err_r   <= err_s;
      end
   end

   assign PCResult        = pc_r;
   assign PCValid         = valid_r;
   assign RedirectPending = rdp_r;
   assign AddrErr         = err_r;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed scenarios followed by random stimulus,
// every cycle compared against a queue-based reference model.
module tb_pc_fetch_ctrl;

   logic        Clk = 1'b0;
   logic        Rst;
   logic [31:0] PCAddResult;
   logic        BranchTaken;
   logic [31:0] BranchTarget;
   logic        Jump;
   logic [31:0] JumpTarget;
   logic        JumpReg;
   logic [31:0] JumpRegTarget;
   logic        Stall;
   logic [31:0] PCResult;
   logic        PCValid;
   logic        RedirectPending;
   logic        AddrErr;

   int tests_run    = 0;
   int tests_failed = 0;

   // Reference model state
   bit          m_valid;
   logic [31:0] m_pc;
   logic [31:0] pend_q[$];
   bit          m_err;

   pc_fetch_ctrl #(.RESET_PC(32'h00000000)) dut (
      .Clk             (Clk),
      .Rst             (Rst),
      .PCAddResult     (PCAddResult),
      .BranchTaken     (BranchTaken),
      .BranchTarget    (BranchTarget),
      .Jump            (Jump),
      .JumpTarget      (JumpTarget),
      .JumpReg         (JumpReg),
      .JumpRegTarget   (JumpRegTarget),
      .Stall           (Stall),
      .PCResult        (PCResult),
      .PCValid         (PCValid),
      .RedirectPending (RedirectPending),
      .AddrErr         (AddrErr)
   );

   // Free-running clock, period 10.
   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_valid = 1'b0;
      m_pc    = 32'h00000000;
      pend_q.delete();
      m_err   = 1'b0;
   endfunction

   // One clock edge of the behavioural model, using the inputs now applied.
   function automatic void model_edge();
      logic [31:0] t;
      bit          r;
      t     = 32'h0;
      r     = 1'b1;
      m_err = 1'b0;
      if (Rst) begin
         model_reset();
         return;
      end
      if (!m_valid) begin
         m_valid = 1'b1;
         return;
      end
      if (pend_q.size() > 0) begin
         if (!Stall) m_pc = pend_q.pop_front();
         return;
      end
      if (JumpReg)          t = JumpRegTarget;
      else if (Jump)        t = JumpTarget;
      else if (BranchTaken) t = BranchTarget;
      else                  r = 1'b0;
      if (r) begin
         m_err = ((t % 4) != 0);
         t     = t - (t % 4);
         if (Stall) pend_q.push_back(t);
         else       m_pc = t;
      end else if (!Stall) begin
         m_pc = PCAddResult;
      end
   endfunction

   task automatic check_all();
      check("pc",      PCResult,        m_pc);
      check("valid",   PCValid,         m_valid);
      check("pending", RedirectPending, (pend_q.size() != 0));
      check("addrerr", AddrErr,         m_err);
   endtask

   task automatic clear_redirects();
      BranchTaken = 1'b0;
      Jump        = 1'b0;
      JumpReg     = 1'b0;
   endtask

   // Advance one clock, update the model, compare, then default the adder input.
   task automatic step();
      @(posedge Clk);
      model_edge();
      #1;
      check_all();
      PCAddResult = m_pc + 32'd4;
   endtask

   initial begin
      Rst = 1'b0;
      Stall = 1'b0;
      clear_redirects();
      BranchTarget  = 32'h0;
      JumpTarget    = 32'h0;
      JumpRegTarget = 32'h0;
      PCAddResult   = 32'd4;
      model_reset();
      #1 Rst = 1'b1;
      #2 check_all();
      step();
      step();

      // Reset release: cycle 0 invalid, then 0, 4, 8, 12.
      Rst = 1'b0;
      #1 check_all();
      check("c0_valid", PCValid, 32'd0);
      step();
      check("seq0", PCResult, 32'd0);
      step();
      step();
      step();
      check("seq12", PCResult, 32'd12);
      step();
      check("seq16", PCResult, 32'h10);

      // Simultaneous branch and jump: jump wins.
      BranchTaken = 1'b1; BranchTarget = 32'h40;
      Jump = 1'b1;        JumpTarget   = 32'h80;
      step();
      check("prio_jump", PCResult, 32'h80);
      clear_redirects();
      step();
      check("after_jump", PCResult, 32'h84);

      // Stalled redirects: the first one is kept.
      Stall = 1'b1; BranchTaken = 1'b1; BranchTarget = 32'h200;
      step();
      check("hold_pc", PCResult, 32'h84);
      check("hold_pend", RedirectPending, 32'd1);
      BranchTaken = 1'b0; JumpReg = 1'b1; JumpRegTarget = 32'h300;
      step();
      JumpReg = 1'b0;
      step();
      check("hold_pc3", PCResult, 32'h84);
      Stall = 1'b0;
      step();
      check("pend_apply", PCResult, 32'h200);
      check("pend_clear", RedirectPending, 32'd0);

      // Misaligned jump target.
      Jump = 1'b1; JumpTarget = 32'h00000103;
      step();
      check("align_pc", PCResult, 32'h100);
      check("align_err", AddrErr, 32'd1);
      Jump = 1'b0;
      step();
      check("err_pulse", AddrErr, 32'd0);

      // Asynchronous reset while holding a pending redirect.
      Stall = 1'b1; BranchTaken = 1'b1; BranchTarget = 32'h500;
      step();
      BranchTaken = 1'b0;
      #2 Rst = 1'b1;
      #1 model_reset();
      check_all();
      check("rst_async_pc", PCResult, 32'd0);
      step();
      Stall = 1'b0;
      Rst = 1'b0;
      step();
      check("rst_restart0", PCResult, 32'd0);
      step();
      check("rst_restart4", PCResult, 32'd4);
      step();
      check("rst_no500", (PCResult == 32'h500), 32'd0);

      // Adder wrap from the top of the address space.
      Jump = 1'b1; JumpTarget = 32'hFFFFFFFC;
      step();
      Jump = 1'b0;
      PCAddResult = 32'h00000000;
      step();
      check("wrap_pc", PCResult, 32'h0);
      check("wrap_err", AddrErr, 32'd0);

      // Random phase.
      for (int i = 0; i < 500; i++) begin
         Stall         = ($urandom_range(0, 9) < 4);
         BranchTaken   = ($urandom_range(0, 9) < 3);
         Jump          = ($urandom_range(0, 9) < 2);
         JumpReg       = ($urandom_range(0, 9) < 2);
         BranchTarget  = $urandom();
         JumpTarget    = $urandom();
         JumpRegTarget = $urandom();
         if ($urandom_range(0, 3) == 0) PCAddResult = $urandom();
         Rst = ($urandom_range(0, 59) == 0);
         step();
      end
      Rst = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000: PC value loaded on reset.
REQ-002 Clk  input  1  single clock; all state updates on rising edge.
REQ-003 Rst  input  1  asynchronous, active-high reset.
REQ-004 PCAddResult  input  32  sequential next address (current PCResult + 4), from the PC adder.
REQ-005 BranchTaken  input  1  branch resolved taken this cycle.
REQ-006 BranchTarget  input  32  branch destination.
REQ-007 Jump  input  1  direct jump this cycle.
REQ-008 JumpTarget  input  32  jump destination.
REQ-009 JumpReg  input  1  register jump this cycle.
REQ-010 JumpRegTarget  input  32  register-jump destination.
REQ-011 Stall  input  1  hold PC; fetch must not advance.
REQ-012 PCResult  output  32  current fetch address; drives the PC adder and instruction memory.
REQ-013 PCValid  output  1  PCResult is a valid fetch address this cycle.
REQ-014 RedirectPending  output  1  a redirect is captured and waiting for Stall to drop.
REQ-015 AddrErr  output  1  one-cycle pulse: an applied or captured redirect target had bits [1:0] != 00.

Function
REQ-016 Redirect priority per cycle SHALL be JumpReg > Jump > BranchTaken; lower-priority requests in the same cycle are discarded.
REQ-017 Every redirect target SHALL have bits [1:0] forced to 00 before use; AddrErr SHALL pulse in the cycle after the offending request is sampled.
REQ-018 States SHALL be INIT, RUN, HOLD.
REQ-019 INIT: entered on reset; PCResult = RESET_PC, PCValid = 0; SHALL transition to RUN on the first clock edge after Rst deasserts, with PC unchanged.
REQ-020 RUN, Stall = 0, no redirect: PC <= PCAddResult on the edge (1-cycle latency).
REQ-021 RUN, Stall = 0, redirect: PC <= selected target on the edge; remain in RUN.
REQ-022 RUN, Stall = 1, no redirect: PC holds; remain in RUN.
REQ-023 RUN, Stall = 1, redirect: PC holds; selected target SHALL be captured into the pending register; go to HOLD; RedirectPending = 1 from the next cycle.
REQ-024 HOLD, Stall = 1: PC and pending register hold; further redirect inputs SHALL be ignored (older redirect wins).
REQ-025 HOLD, Stall = 0: PC <= pending target; go to RUN; RedirectPending clears on the same edge; any redirect input in that cycle SHALL be ignored.
REQ-026 PCValid SHALL be 1 in RUN and HOLD, and 0 in INIT.
REQ-027 PC arithmetic is supplied externally; the block SHALL NOT add; PCAddResult wrap from 32'hFFFFFFFC to 32'h00000000 SHALL be accepted unchanged.
REQ-028 Outputs SHALL be registered; no combinational path from any input to PCResult.

Reset
REQ-029 Asserting Rst SHALL immediately, without a clock, force PCResult = RESET_PC, PCValid = 0, RedirectPending = 0, AddrErr = 0, state = INIT, pending register = 0.
REQ-030 Reset asserted mid-HOLD SHALL discard the pending redirect; no pending target SHALL be applied after reset release.

Verification
REQ-031 Release Rst, Stall = 0, adder model PC + 4 -> cycle 0: PCValid = 0, PCResult = 0; then PCResult = 0, 4, 8, 12 on successive cycles with PCValid = 1.
REQ-032 At PC = 0x10, assert BranchTaken = 1, BranchTarget = 0x40, Jump = 1, JumpTarget = 0x80 together -> next PCResult = 0x80; following cycle 0x84.
REQ-033 Stall = 1 for 3 cycles with BranchTaken and target 0x200 on the first stalled cycle, then JumpReg and target 0x300 on the second -> PC holds, RedirectPending = 1; first unstalled edge gives PCResult = 0x200, RedirectPending = 0.
REQ-034 Jump with JumpTarget = 0x00000103 -> PCResult = 0x00000100; AddrErr high for exactly one cycle.
REQ-035 Assert Rst asynchronously between edges while in HOLD with a pending target of 0x500 -> outputs reset at once; after release, PC sequence restarts 0, 4, never 0x500.
REQ-036 PCAddResult = 0x00000000 while PCResult = 0xFFFFFFFC -> PCResult wraps to 0x00000000, no AddrErr.
